// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg : shared widths and ALU control encodings for the operand stage
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  localparam int XLEN      = 32;
  localparam int NREGS     = 32;
  localparam int REG_IDX_W = 5;
  localparam int CTRL_W    = 3;

  localparam logic [CTRL_W-1:0] ALU_ADD = 3'b000;
  localparam logic [CTRL_W-1:0] ALU_SUB = 3'b001;
  localparam logic [CTRL_W-1:0] ALU_AND = 3'b010;
  localparam logic [CTRL_W-1:0] ALU_XOR = 3'b011;
  localparam logic [CTRL_W-1:0] ALU_SLT = 3'b101;

  function automatic logic is_legal_ctrl(input logic [CTRL_W-1:0] ctrl);
    logic legal;
    case (ctrl)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR, ALU_SLT: legal = 1'b1;
      default:                                     legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_operand_stage_if.sv
// ---------------------------------------------------------------------------
// alu_operand_stage_if : issue, write-back and ALU-side handshake bundle
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface alu_operand_stage_if;
  import alu_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [REG_IDX_W-1:0] in_rs1;
  logic [REG_IDX_W-1:0] in_rs2;
  logic                 in_use_imm;
  logic [XLEN-1:0]      in_imm;
  logic [CTRL_W-1:0]    in_ctrl;
  logic [REG_IDX_W-1:0] in_rd;

  logic                 wb_en;
  logic [REG_IDX_W-1:0] wb_addr;
  logic [XLEN-1:0]      wb_data;

  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      out_a;
  logic [XLEN-1:0]      out_b;
  logic [CTRL_W-1:0]    out_ctrl;
  logic [REG_IDX_W-1:0] out_rd;
  logic                 out_illegal;

  modport master (
    output in_valid, in_rs1, in_rs2, in_use_imm, in_imm, in_ctrl, in_rd,
    output wb_en, wb_addr, wb_data,
    output out_ready,
    input  in_ready,
    input  out_valid, out_a, out_b, out_ctrl, out_rd, out_illegal
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_use_imm, in_imm, in_ctrl, in_rd,
    input  wb_en, wb_addr, wb_data,
    input  out_ready,
    output in_ready,
    output out_valid, out_a, out_b, out_ctrl, out_rd, out_illegal
  );

endinterface

`default_nettype wire

// File: rtl/reg_file_2r1w.sv
// ---------------------------------------------------------------------------
// reg_file_2r1w : integer register file, two combinational reads, one write
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module reg_file_2r1w #(
  parameter int NREGS = 32,
  parameter int XLEN  = 32,
  parameter int IDX_W = 5
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_wen,
  input  wire logic [IDX_W-1:0] i_waddr,
  input  wire logic [XLEN-1:0]  i_wdata,
  input  wire logic [IDX_W-1:0] i_raddr1,
  input  wire logic [IDX_W-1:0] i_raddr2,
  output logic      [XLEN-1:0]  o_rdata1,
  output logic      [XLEN-1:0]  o_rdata2
);

  logic [XLEN-1:0] r_regs [NREGS];
  logic            w_wr_live;

  // x0 is never written, so its entry keeps the reset value forever
  assign w_wr_live = i_wen && (i_waddr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_live) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  always_comb begin
    o_rdata1 = r_regs[i_raddr1];
    if (i_raddr1 == '0) begin
      o_rdata1 = '0;
    end else if (w_wr_live && (i_waddr == i_raddr1)) begin
      o_rdata1 = i_wdata;
    end
  end

  always_comb begin
    o_rdata2 = r_regs[i_raddr2];
    if (i_raddr2 == '0) begin
      o_rdata2 = '0;
    end else if (w_wr_live && (i_waddr == i_raddr2)) begin
      o_rdata2 = i_wdata;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_operand_stage.sv
// ---------------------------------------------------------------------------
// alu_operand_stage : register read + operand select into a one-entry slot
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int NREGS = alu_pkg::NREGS,
  parameter int XLEN  = alu_pkg::XLEN
) (
  input  wire logic          clk,
  input  wire logic          reset,
  alu_operand_stage_if.slave bus
);

  logic [XLEN-1:0]      w_rdata1;
  logic [XLEN-1:0]      w_rdata2;
  logic                 w_accept;

  logic                 r_valid;
  logic [XLEN-1:0]      r_a;
  logic [XLEN-1:0]      r_b;
  logic [CTRL_W-1:0]    r_ctrl;
  logic [REG_IDX_W-1:0] r_rd;
  logic                 r_illegal;

  reg_file_2r1w #(
    .NREGS (NREGS),
    .XLEN  (XLEN),
    .IDX_W (REG_IDX_W)
  ) u_rf (
    .clk      (clk),
    .rst      (reset),
    .i_wen    (bus.wb_en),
    .i_waddr  (bus.wb_addr),
    .i_wdata  (bus.wb_data),
    .i_raddr1 (bus.in_rs1),
    .i_raddr2 (bus.in_rs2),
    .o_rdata1 (w_rdata1),
    .o_rdata2 (w_rdata2)
  );

  assign bus.in_ready = !r_valid || bus.out_ready;
  assign w_accept     = bus.in_valid && bus.in_ready;

  // Payload only moves on accept; a drain just clears valid
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_ctrl    <= '0;
      r_rd      <= '0;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_a       <= w_rdata1;
      r_b       <= bus.in_use_imm ? bus.in_imm : w_rdata2;
      r_ctrl    <= bus.in_ctrl;
      r_rd      <= bus.in_rd;
      r_illegal <= !is_legal_ctrl(bus.in_ctrl);
    end else if (bus.out_ready) begin
      r_valid   <= 1'b0;
    end
  end

  assign bus.out_valid   = r_valid;
  assign bus.out_a       = r_a;
  assign bus.out_b       = r_b;
  assign bus.out_ctrl    = r_ctrl;
  assign bus.out_rd      = r_rd;
  assign bus.out_illegal = r_illegal;

endmodule

`default_nettype wire

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
Register-file and operand-select stage directly upstream of the 32-bit ALU. It holds the 32x32 integer register file and accepts one operation per cycle: source register indices, an optional immediate and an ALU control code. It reads and selects the two operands, bypassing any same-cycle write-back. The operands, control code and destination index are presented to the ALU through one registered output slot with a valid/ready handshake.

Parameters:
NREGS, 32, number of architectural registers (index width = log2(NREGS) = 5)
XLEN, 32, operand/register width

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  upstream presents an operation
in_ready  output  1  stage can accept this cycle
in_rs1  input  5  source register index for operand A
in_rs2  input  5  source register index for operand B
in_use_imm  input  1  1: operand B = in_imm; 0: operand B = reg[in_rs2]
in_imm  input  32  immediate value
in_ctrl  input  3  ALU control code
in_rd  input  5  destination index, carried through unchanged
wb_en  input  1  write-back enable
wb_addr  input  5  write-back register index
wb_data  input  32  write-back data
out_valid  output  1  output slot holds a valid operation
out_ready  input  1  ALU side accepts this cycle
out_a  output  32  operand A to ALU a
out_b  output  32  operand B to ALU b
out_ctrl  output  3  to ALUControl
out_rd  output  5  destination index
out_illegal  output  1  registered out_ctrl is an unsupported code

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- Reset (at the clk edge with reset=1):
  - all registers become 0
  - out_valid=0; out_a, out_b, out_ctrl, out_rd, out_illegal all become 0
  - reset dominates wb_en and in_valid in the same cycle
- Register 0 is hardwired to zero: writes to index 0 are dropped, reads of index 0 return 0, and no bypass applies to index 0.
- Write port: if wb_en=1 and wb_addr!=0, reg[wb_addr]<=wb_data at the clk edge.
- Read bypass: if wb_en=1, wb_addr==rsX and rsX!=0 in the same cycle, the operand uses wb_data, not the stale array value.
- Acceptance:
  - accept = in_valid && in_ready
  - in_ready = !out_valid || out_ready (combinational; single-entry slot)
- On accept, at the clk edge:
  - out_a <= bypassed reg[in_rs1]
  - out_b <= in_use_imm ? in_imm : bypassed reg[in_rs2]
  - out_ctrl <= in_ctrl; out_rd <= in_rd
  - out_illegal <= (in_ctrl is not one of 000, 001, 010, 011, 101)
  - out_valid <= 1
- Latency: one cycle from accept to out_valid.
- Throughput: one operation per cycle while out_ready=1.
- Drain without refill: out_valid && out_ready && !accept -> out_valid <= 0; payload registers hold their values.
- Stall: out_valid=1 and out_ready=0 -> in_ready=0 and all out_* are held stable.
- Operands are sampled once, at accept. A later write-back to a source register does not update a held operand; ordering hazards are the upstream issuer's responsibility.
- Simultaneous drain and accept in one cycle: the new operation replaces the old one with no bubble.
- out_illegal is informational only. The operation still issues, and the ALU returns 0 for unsupported codes.
- Reset mid-stall discards the held operation.

Decomposition:
- Shared package alu_pkg:
  - XLEN, REG_IDX_W=5
  - ALU control constants: ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_XOR=3'b011, ALU_SLT=3'b101
  - function is_legal_ctrl
- One sub-module: reg_file_2r1w, containing the array, the two combinational read ports, the write port, x0 handling and the write-to-read bypass.
- The handshake/output slot stays in the top module.

Test Plan:
- Reset, then write x5=0x0000_0010 and x6=0x0000_0003; issue rs1=5, rs2=6, ctrl=001, rd=7 with out_ready=1 -> next cycle out_valid=1, out_a=0x10, out_b=0x3, out_ctrl=001, out_rd=7, out_illegal=0.
- Bypass: in the same cycle issue rs1=9 and wb_en=1, wb_addr=9, wb_data=0xDEAD_BEEF -> out_a=0xDEAD_BEEF.
- x0: write x0=0xFFFF_FFFF, then issue rs1=0, use_imm=1, imm=0x1234 -> out_a=0, out_b=0x1234.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 throughout, out_* stable. Then raise out_ready -> back-to-back transfer with no bubble, and the second operation appears in the following cycle.
- Illegal code: issue ctrl=3'b110 -> out_valid=1, out_illegal=1, out_ctrl=110.
- Reset while out_valid=1 and stalled -> next cycle out_valid=0, all outputs 0, and a read of x5 returns 0.
